// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM compare / dead-band slice.
package pwm_pkg;

    // Dead-band FSM states; value 3 is unused and recovers to S_DT.
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_DT   = 2'd1,
        S_HIGH = 2'd2
    } pwm_state_t;

    // Default output polarity: 0 = active-high outputs.
    localparam logic PWM_POLARITY_DEF = 1'b0;

endpackage

// File: rtl/pwm_deadband.sv
// Complementary PWM generator with programmable dead band.
// Any change of the compare result passes through S_DT for dt_i+1 cycles,
// so the high-side and low-side outputs are never active together.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int   DT_W     = 4,
    parameter logic POLARITY = PWM_POLARITY_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            raw_i,
    input  logic [DT_W-1:0] dt_i,
    output logic            pwm_o,
    output logic            pwm_n_o
);

    localparam logic [DT_W-1:0] DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

    pwm_state_t      state_q, state_d;
    logic            target_q, target_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic            pwm_q, pwm_n_q;

    // Next-state: a toggle of raw_i while in the band restarts the dead-time count.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            S_LOW: begin
                if (raw_i) begin
                    state_d  = S_DT;
                    target_d = 1'b1;
                    dt_cnt_d = dt_i;
                end
            end
            S_HIGH: begin
                if (!raw_i) begin
                    state_d  = S_DT;
                    target_d = 1'b0;
                    dt_cnt_d = dt_i;
                end
            end
            S_DT: begin
                if (raw_i != target_q) begin
                    target_d = raw_i;
                    dt_cnt_d = dt_i;
                end else if (dt_cnt_q == '0) begin
                    state_d = target_q ? S_HIGH : S_LOW;
                end else begin
                    dt_cnt_d = dt_cnt_q - DT_ONE;
                end
            end
            default: begin
                state_d  = S_DT;
                target_d = 1'b0;
                dt_cnt_d = '0;
            end
        endcase
    end

    // State and registered outputs; outputs decode the state being entered so they track state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_DT;
            target_q <= 1'b0;
            dt_cnt_q <= '0;
            pwm_q    <= POLARITY;
            pwm_n_q  <= POLARITY;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dt_cnt_q <= dt_cnt_d;
            pwm_q    <= (state_d == S_HIGH) ^ POLARITY;
            pwm_n_q  <= (state_d == S_LOW)  ^ POLARITY;
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pwm_compare.sv
// Counter-compare PWM with double-buffered duty and dead-band output stage.
// A new duty is parked in the shadow register and only promoted at a period
// boundary, so every period is generated from a single duty value.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   DT_W     = 4,
    parameter logic POLARITY = PWM_POLARITY_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] cnt_value_i,
    input  logic             duty_valid_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             duty_ready_o,
    input  logic [DT_W-1:0]  dt_i,
    output logic             pwm_o,
    output logic             pwm_n_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             raw_q;
    logic             wrap_q;
    logic             boundary;
    logic             accept;

    // Edge into zero only: a counter parked at 0 yields one boundary, a preset to 0 yields one.
    assign boundary     = (cnt_value_i == '0) && (prev_q != '0);
    assign accept       = duty_valid_i && !pending_q;
    assign duty_ready_o = !pending_q;
    assign wrap_o       = wrap_q;

    // Double buffer: promote at a boundary, otherwise accept into the shadow when free.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = duty_i;
            pending_d = 1'b1;
        end
    end

    // Registers; compare uses the freshly promoted duty so a new value applies from count 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            raw_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            prev_q    <= cnt_value_i;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            raw_q     <= (cnt_value_i < active_d);
            wrap_q    <= boundary;
        end
    end

    pwm_deadband #(
        .DT_W     (DT_W),
        .POLARITY (POLARITY)
    ) u_deadband (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .raw_i   (raw_q),
        .dt_i    (dt_i),
        .pwm_o   (pwm_o),
        .pwm_n_o (pwm_n_o)
    );

endmodule
